// File: rtl/updown_step_sequencer_pkg.sv
// Shared types and constants for the up/down step sequencer and its downstream counter.
package updown_step_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        STEP  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Counter mode encoding, shared with the counter side.
    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // True while a command owns the counter.
    function automatic logic is_active(input state_e s);
        return (s == SETUP) || (s == STEP) || (s == GAP);
    endfunction

endpackage

// File: rtl/updown_step_sequencer_step_gap_timer.sv
// Loadable down-counter that flags expiry of the inter-step gap.
module updown_step_sequencer_step_gap_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired_c
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/updown_step_sequencer.sv
// Command front-end for the up/down counter: turns "move N steps" commands into
// one-cycle count enables while tracking a shadow copy of the counter value.
module updown_step_sequencer
    import updown_step_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned STEP_W = 8,
    parameter int unsigned DIV    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    output logic              cnt_en,
    output logic              cnt_mode,
    output logic [WIDTH-1:0]  pos,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              wrap
);

    localparam int unsigned TIMER_W  = $clog2(DIV) + 1;
    // A gap of DIV-1 cycles: the loaded value plus the expiry cycle.
    localparam int unsigned GAP_LOAD = (DIV > 1) ? (DIV - 2) : 0;
    localparam logic [WIDTH-1:0] POS_MAX = '1;

    state_e              state_d,     state_q;
    logic [STEP_W-1:0]   remaining_d, remaining_q;
    logic [WIDTH-1:0]    pos_d,       pos_q;
    logic                cnt_mode_d,  cnt_mode_q;
    logic                cnt_en_d,    cnt_en_q;
    logic                cmd_ready_d, cmd_ready_q;
    logic                busy_d,      busy_q;
    logic                done_d,      done_q;
    logic                aborted_d,   aborted_q;
    logic                wrap_d,      wrap_q;

    logic                timer_load;
    logic                timer_dec;
    logic                timer_expired;

    updown_step_sequencer_step_gap_timer #(
        .W (TIMER_W)
    ) u_step_gap_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load),
        .load_val  (TIMER_W'(GAP_LOAD)),
        .dec       (timer_dec),
        .expired_c (timer_expired)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pos_d       = pos_q;
        cnt_mode_d  = cnt_mode_q;
        aborted_d   = 1'b0;
        wrap_d      = 1'b0;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    remaining_d = cmd_steps;
                    if (cmd_steps == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = SETUP;
                        cnt_mode_d = cmd_dir;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = STEP;
                end
            end
            STEP: begin
                // The enable issued this cycle always counts, even under abort.
                if (cnt_mode_q == MODE_UP) begin
                    pos_d  = pos_q + WIDTH'(1);
                    wrap_d = (pos_q == POS_MAX);
                end else begin
                    pos_d  = pos_q - WIDTH'(1);
                    wrap_d = (pos_q == '0);
                end
                remaining_d = remaining_q - STEP_W'(1);
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (remaining_q == STEP_W'(1)) begin
                    state_d = DONE;
                end else if (DIV > 1) begin
                    state_d    = GAP;
                    timer_load = 1'b1;
                end else begin
                    state_d = STEP;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (timer_expired) begin
                    state_d = STEP;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cnt_en_d    = (state_d == STEP);
        cmd_ready_d = (state_d == IDLE);
        busy_d      = is_active(state_d);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            pos_q       <= '0;
            cnt_mode_q  <= MODE_UP;
            cnt_en_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pos_q       <= pos_d;
            cnt_mode_q  <= cnt_mode_d;
            cnt_en_q    <= cnt_en_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            wrap_q      <= wrap_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cnt_en    = cnt_en_q;
    assign cnt_mode  = cnt_mode_q;
    assign pos       = pos_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_updown_step_sequencer.sv
// Directed bench for updown_step_sequencer: a DIV=1 instance for most scenarios and a DIV=3 instance for gap timing.
module tb_updown_step_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
    logic [7:0] cmd_steps = 8'd0;
    logic       cmd_ready, cnt_en, cnt_mode, busy, done, aborted, wrap;
    logic [2:0] pos;

    logic       d3_valid = 1'b0, d3_dir = 1'b0, d3_abort = 1'b0;
    logic [7:0] d3_steps = 8'd0;
    logic       d3_ready, d3_en, d3_mode, d3_busy, d3_done, d3_aborted, d3_wrap;
    logic [2:0] d3_pos;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updown_step_sequencer #(.WIDTH(3), .STEP_W(8), .DIV(1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort), .cnt_en(cnt_en),
        .cnt_mode(cnt_mode), .pos(pos), .busy(busy), .done(done),
        .aborted(aborted), .wrap(wrap)
    );

    updown_step_sequencer #(.WIDTH(3), .STEP_W(8), .DIV(3)) dut3 (
        .clk(clk), .reset(reset), .cmd_valid(d3_valid), .cmd_ready(d3_ready),
        .cmd_dir(d3_dir), .cmd_steps(d3_steps), .abort(d3_abort), .cnt_en(d3_en),
        .cnt_mode(d3_mode), .pos(d3_pos), .busy(d3_busy), .done(d3_done),
        .aborted(d3_aborted), .wrap(d3_wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle; returns in the SETUP (or DONE) cycle.
    task automatic send_cmd(input logic dir, input logic [7:0] steps);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = steps;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++; if ({cmd_ready, cnt_en, cnt_mode, busy, done, aborted, wrap} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000000", {cmd_ready, cnt_en, cnt_mode, busy, done, aborted, wrap}); end
        checks++; if (pos !== 3'd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", pos); end
        checks++; if ({d3_ready, d3_en, d3_busy, d3_done, d3_pos} !== 7'b0) begin
            errors++; $display("FAIL reset_dut3: got %b expected 0000000", {d3_ready, d3_en, d3_busy, d3_done, d3_pos}); end
        reset = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
        checks++; if ({cnt_en, busy, done} !== 3'b0) begin errors++; $display("FAIL reset_release_flags: got %b expected 000", {cnt_en, busy, done}); end
    endtask

    task automatic test_up_n5();
        logic wrap_seen = 1'b0;
        send_cmd(1'b0, 8'd5);
        checks++; if ({cnt_mode, cnt_en, busy, cmd_ready} !== 4'b0010) begin
            errors++; $display("FAIL up5_setup: got %b expected 0010", {cnt_mode, cnt_en, busy, cmd_ready}); end
        for (int i = 0; i < 5; i++) begin
            tick();
            wrap_seen = wrap_seen | wrap;
            checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL up5_en[%0d]: got %b expected 1", i, cnt_en); end
            checks++; if (pos !== 3'(i)) begin errors++; $display("FAIL up5_pos[%0d]: got %0d expected %0d", i, pos, i); end
        end
        tick();
        wrap_seen = wrap_seen | wrap;
        checks++; if ({done, aborted, cnt_en, busy} !== 4'b1000) begin
            errors++; $display("FAIL up5_done: got %b expected 1000", {done, aborted, cnt_en, busy}); end
        checks++; if (pos !== 3'd5) begin errors++; $display("FAIL up5_final_pos: got %0d expected 5", pos); end
        checks++; if (wrap_seen !== 1'b0) begin errors++; $display("FAIL up5_wrap: got %b expected 0", wrap_seen); end
        tick();
        checks++; if ({cmd_ready, done} !== 2'b10) begin errors++; $display("FAIL up5_ready: got %b expected 10", {cmd_ready, done}); end
    endtask

    task automatic test_wrap_up();
        send_cmd(1'b0, 8'd3);
        repeat (4) tick();
        checks++; if ({done, wrap} !== 2'b11) begin errors++; $display("FAIL wrapup_done: got %b expected 11", {done, wrap}); end
        checks++; if (pos !== 3'd0) begin errors++; $display("FAIL wrapup_pos: got %0d expected 0", pos); end
        tick();
    endtask

    task automatic test_down_n2();
        send_cmd(1'b1, 8'd2);
        checks++; if (cnt_mode !== 1'b1) begin errors++; $display("FAIL down2_mode: got %b expected 1", cnt_mode); end
        tick();
        checks++; if ({cnt_en, wrap, pos} !== 5'b10_000) begin errors++; $display("FAIL down2_step1: got %b expected 10000", {cnt_en, wrap, pos}); end
        tick();
        checks++; if ({cnt_en, wrap, pos} !== 5'b11_111) begin errors++; $display("FAIL down2_step2: got %b expected 11111", {cnt_en, wrap, pos}); end
        tick();
        checks++; if ({done, aborted, wrap, pos} !== 6'b100_110) begin
            errors++; $display("FAIL down2_done: got %b expected 100110", {done, aborted, wrap, pos}); end
        tick();
    endtask

    task automatic test_abort();
        send_cmd(1'b0, 8'd10);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL abort_en[%0d]: got %b expected 1", i, cnt_en); end
            if (i == 3) abort = 1'b1;
        end
        tick();
        abort = 1'b0;
        checks++; if ({done, aborted, cnt_en} !== 3'b110) begin errors++; $display("FAIL abort_done: got %b expected 110", {done, aborted, cnt_en}); end
        checks++; if (pos !== 3'd2) begin errors++; $display("FAIL abort_pos: got %0d expected 2", pos); end
        tick();
        checks++; if ({cmd_ready, aborted, cnt_en} !== 3'b100) begin errors++; $display("FAIL abort_idle: got %b expected 100", {cmd_ready, aborted, cnt_en}); end
    endtask

    task automatic test_abort_in_idle();
        abort = 1'b1;
        send_cmd(1'b0, 8'd1);
        abort = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idleabort_busy: got %b expected 1", busy); end
        tick();
        checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL idleabort_en: got %b expected 1", cnt_en); end
        tick();
        checks++; if ({done, aborted, pos} !== 5'b10_011) begin errors++; $display("FAIL idleabort_done: got %b expected 10011", {done, aborted, pos}); end
        tick();
    endtask

    task automatic test_zero_steps();
        send_cmd(1'b1, 8'd0);
        checks++; if ({done, cnt_en, busy, cmd_ready, cnt_mode} !== 5'b10000) begin
            errors++; $display("FAIL zero_done: got %b expected 10000", {done, cnt_en, busy, cmd_ready, cnt_mode}); end
        checks++; if (pos !== 3'd3) begin errors++; $display("FAIL zero_pos: got %0d expected 3", pos); end
        tick();
        checks++; if ({cmd_ready, done} !== 2'b10) begin errors++; $display("FAIL zero_ready: got %b expected 10", {cmd_ready, done}); end
    endtask

    task automatic test_back_to_back();
        int gap_en = 0;
        send_cmd(1'b0, 8'd1);
        tick();
        checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL b2b_first_en: got %b expected 1", cnt_en); end
        tick();
        gap_en += int'(cnt_en);
        tick();
        gap_en += int'(cnt_en);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", cmd_ready); end
        send_cmd(1'b1, 8'd1);
        gap_en += int'(cnt_en);
        checks++; if (gap_en != 0) begin errors++; $display("FAIL b2b_gap_en: got %0d expected 0", gap_en); end
        tick();
        checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL b2b_second_en: got %b expected 1", cnt_en); end
        tick();
        checks++; if ({done, pos} !== 4'b1_011) begin errors++; $display("FAIL b2b_done: got %b expected 1011", {done, pos}); end
        tick();
    endtask

    task automatic test_reset_mid_command();
        logic done_seen = 1'b0;
        send_cmd(1'b0, 8'd6);
        tick();
        done_seen = done_seen | done;
        tick();
        done_seen = done_seen | done;
        checks++; if ({cnt_en, pos} !== 4'b1_100) begin errors++; $display("FAIL midrst_step2: got %b expected 1100", {cnt_en, pos}); end
        reset = 1'b0;
        tick();
        done_seen = done_seen | done;
        checks++; if ({cmd_ready, cnt_en, cnt_mode, busy, done, aborted, wrap, pos} !== 10'b0) begin
            errors++; $display("FAIL midrst_outputs: got %b expected 0", {cmd_ready, cnt_en, cnt_mode, busy, done, aborted, wrap, pos}); end
        reset = 1'b1;
        tick();
        done_seen = done_seen | done;
        checks++; if ({cmd_ready, done_seen} !== 2'b10) begin errors++; $display("FAIL midrst_release: got %b expected 10", {cmd_ready, done_seen}); end
    endtask

    task automatic test_div3();
        int pat[7] = '{1, 0, 0, 1, 0, 0, 1};
        d3_valid = 1'b1; d3_dir = 1'b0; d3_steps = 8'd3;
        tick();
        d3_valid = 1'b0;
        checks++; if ({d3_busy, d3_en} !== 2'b10) begin errors++; $display("FAIL div3_setup: got %b expected 10", {d3_busy, d3_en}); end
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (d3_en !== 1'(pat[i])) begin errors++; $display("FAIL div3_en[%0d]: got %b expected %0d", i, d3_en, pat[i]); end
        end
        tick();
        checks++; if ({d3_done, d3_aborted, d3_en, d3_pos} !== 6'b100_011) begin
            errors++; $display("FAIL div3_done: got %b expected 100011", {d3_done, d3_aborted, d3_en, d3_pos}); end
        tick();
        checks++; if (d3_ready !== 1'b1) begin errors++; $display("FAIL div3_ready: got %b expected 1", d3_ready); end
    endtask

    initial begin
        test_reset();
        test_up_n5();
        test_wrap_up();
        test_down_n2();
        test_abort();
        test_abort_in_idle();
        test_zero_steps();
        test_back_to_back();
        test_reset_mid_command();
        test_div3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
